// File: rtl/rr_index_arbiter_if.sv
// Request/grant bundle between the round-robin index arbiter and its requester-side logic.
// The arbiter sits on the slave modport; the requester side drives the master modport.
interface rr_index_arbiter_if #(
  parameter int NUM_REQUESTERS = 7
);
  localparam int INDEX_WIDTH = $clog2(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0] request;
  logic                      update_lru;
  logic                      grant_lock;
  logic                      grant_valid;
  logic [INDEX_WIDTH-1:0]    grant_idx;

  modport master (
    output request, update_lru, grant_lock,
    input  grant_valid, grant_idx
  );

  modport slave (
    input  request, update_lru, grant_lock,
    output grant_valid, grant_idx
  );
endinterface

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter returning the winner as a binary index, with an optional grant lock
// that holds one requester across multi-cycle transfers. Works for non-power-of-two widths.
module rr_index_arbiter #(
  parameter int NUM_REQUESTERS = 7
) (
  input logic              clk,
  input logic              reset,
  rr_index_arbiter_if.slave bus
);
  localparam int INDEX_WIDTH = $clog2(NUM_REQUESTERS);
  // One extra bit so ptr + offset can exceed NUM_REQUESTERS-1 before the wrap subtraction.
  localparam int SCAN_W = INDEX_WIDTH + 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_REQUESTERS - 1);

  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic                   locked_q, locked_d;
  logic [INDEX_WIDTH-1:0] lock_idx_q, lock_idx_d;

  logic                   found;
  logic [INDEX_WIDTH-1:0] search_idx;
  logic                   lock_hit;
  logic                   grant_valid;
  logic [INDEX_WIDTH-1:0] grant_idx;

  always_comb begin
    logic [SCAN_W-1:0] pos;
    found      = 1'b0;
    search_idx = '0;
    pos        = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      pos = SCAN_W'(ptr_q) + SCAN_W'(k);
      if (pos >= SCAN_W'(NUM_REQUESTERS)) begin
        pos = pos - SCAN_W'(NUM_REQUESTERS);
      end
      if (!found && bus.request[pos[INDEX_WIDTH-1:0]]) begin
        found      = 1'b1;
        search_idx = pos[INDEX_WIDTH-1:0];
      end
    end
  end

  // A lock whose requester has dropped releases immediately and falls back to the scan.
  assign lock_hit    = locked_q && bus.request[lock_idx_q];
  assign grant_valid = lock_hit || found;
  assign grant_idx   = lock_hit ? lock_idx_q : (found ? search_idx : '0);

  assign bus.grant_valid = grant_valid;
  assign bus.grant_idx   = grant_idx;

  always_comb begin
    ptr_d      = ptr_q;
    locked_d   = 1'b0;
    lock_idx_d = lock_idx_q;
    if (bus.update_lru && grant_valid) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
    if (bus.grant_lock && grant_valid) begin
      locked_d   = 1'b1;
      lock_idx_d = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end
endmodule

// File: tb/tb_rr_index_arbiter.sv
// Self-checking bench for rr_index_arbiter: directed scenarios plus randomized traffic,
// all compared against a modulo-arithmetic reference model of the arbitration rules.
module tb_rr_index_arbiter;
  localparam int N  = 7;
  localparam int IW = $clog2(N);

  logic clk;
  logic reset;

  rr_index_arbiter_if #(.NUM_REQUESTERS(N)) bus ();

  rr_index_arbiter #(.NUM_REQUESTERS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference model state.
  int m_ptr;
  int m_locked;
  int m_lidx;
  int exp_v;
  int exp_i;

  function automatic bit req_bit(input logic [N-1:0] r, input int i);
    logic [N-1:0] t;
    t = r >> i;
    return t[0];
  endfunction

  task automatic model_reset();
    m_ptr    = 0;
    m_locked = 0;
    m_lidx   = 0;
  endtask

  // Apply inputs, let them settle, then compute the expected grant from the model.
  task automatic drive(input logic [N-1:0] req, input logic upd, input logic lk);
    bus.request    = req;
    bus.update_lru = upd;
    bus.grant_lock = lk;
    #1;
    exp_v = 0;
    exp_i = 0;
    if (m_locked != 0 && req_bit(req, m_lidx)) begin
      exp_v = 1;
      exp_i = m_lidx;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (exp_v == 0 && req_bit(req, (m_ptr + k) % N)) begin
          exp_v = 1;
          exp_i = (m_ptr + k) % N;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (bus.update_lru && exp_v != 0) m_ptr = (exp_i + 1) % N;
      if (bus.grant_lock && exp_v != 0) begin
        m_locked = 1;
        m_lidx   = exp_i;
      end else begin
        m_locked = 0;
      end
    end
    #1;
  endtask

  task automatic restart();
    reset = 1'b1;
    model_reset();
    drive('0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0] pats [2];
    pats[0] = 7'h7F;
    pats[1] = 7'b0001100;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      drive(pats[i], 1'b1, 1'b1);
      n_cmp++;
      if (bus.grant_valid !== 1'b1 || bus.grant_idx !== IW'(exp_i) || exp_i != 2 * i) begin
        n_bad++;
        $display("FAIL reset_grant[%0d]: got valid=%0b idx=%0d, want valid=1 idx=%0d",
                 i, bus.grant_valid, bus.grant_idx, 2 * i);
      end
      tick();
    end
    reset = 1'b0;
    drive('0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.grant_valid !== 1'b0 || bus.grant_idx !== '0) begin
      n_bad++;
      $display("FAIL reset_idle: got valid=%0b idx=%0d, want valid=0 idx=0",
               bus.grant_valid, bus.grant_idx);
    end
    tick();
  endtask

  task automatic test_rotation();
    int want [8] = '{0, 1, 2, 3, 4, 5, 6, 0};
    restart();
    for (int i = 0; i < 8; i++) begin
      drive(7'h7F, 1'b1, 1'b0);
      n_cmp++;
      if (bus.grant_valid !== 1'b1 || bus.grant_idx !== IW'(want[i]) || exp_i != want[i]) begin
        n_bad++;
        $display("FAIL rotation[%0d]: got valid=%0b idx=%0d, want valid=1 idx=%0d",
                 i, bus.grant_valid, bus.grant_idx, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] reqs [4];
    int want [4] = '{5, 0, 6, 0};
    reqs[0] = 7'b0100000;  // consume 5 -> ptr 6
    reqs[1] = 7'b0000001;
    reqs[2] = 7'b1000000;  // consume 6 -> ptr must wrap to 0
    reqs[3] = 7'h7F;
    restart();
    for (int i = 0; i < 4; i++) begin
      drive(reqs[i], 1'b1, 1'b0);
      n_cmp++;
      if (bus.grant_valid !== 1'b1 || bus.grant_idx !== IW'(want[i]) || exp_i != want[i]) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got valid=%0b idx=%0d, want valid=1 idx=%0d",
                 i, bus.grant_valid, bus.grant_idx, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_idle();
    restart();
    drive(7'b0000010, 1'b1, 1'b0);  // ptr -> 2
    tick();
    for (int i = 0; i < 3; i++) begin
      drive('0, 1'b1, 1'b0);
      n_cmp++;
      if (bus.grant_valid !== 1'b0 || bus.grant_idx !== '0) begin
        n_bad++;
        $display("FAIL idle[%0d]: got valid=%0b idx=%0d, want valid=0 idx=0",
                 i, bus.grant_valid, bus.grant_idx);
      end
      tick();
    end
    drive(7'b0010000, 1'b0, 1'b0);
    n_cmp++;
    if (bus.grant_valid !== 1'b1 || bus.grant_idx !== IW'(4)) begin
      n_bad++;
      $display("FAIL idle_then_req: got valid=%0b idx=%0d, want valid=1 idx=4",
               bus.grant_valid, bus.grant_idx);
    end
    tick();
    drive(7'h7F, 1'b0, 1'b0);
    n_cmp++;
    if (bus.grant_valid !== 1'b1 || bus.grant_idx !== IW'(2)) begin
      n_bad++;
      $display("FAIL idle_ptr_kept: got valid=%0b idx=%0d, want valid=1 idx=2",
               bus.grant_valid, bus.grant_idx);
    end
    tick();
  endtask

  task automatic test_lock();
    restart();
    for (int i = 0; i < 2; i++) begin
      drive(7'h7F, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(7'h7F, 1'b1, 1'b1);
      n_cmp++;
      if (bus.grant_valid !== 1'b1 || bus.grant_idx !== IW'(2)) begin
        n_bad++;
        $display("FAIL lock_hold[%0d]: got valid=%0b idx=%0d, want valid=1 idx=2",
                 i, bus.grant_valid, bus.grant_idx);
      end
      tick();
    end
    drive(7'h7F, 1'b1, 1'b0);  // lock still registered this cycle
    n_cmp++;
    if (bus.grant_idx !== IW'(exp_i)) begin
      n_bad++;
      $display("FAIL lock_drop_cycle: got idx=%0d, want idx=%0d", bus.grant_idx, exp_i);
    end
    tick();
    drive(7'h7F, 1'b1, 1'b0);
    n_cmp++;
    if (bus.grant_valid !== 1'b1 || bus.grant_idx !== IW'(3)) begin
      n_bad++;
      $display("FAIL lock_after_drop: got valid=%0b idx=%0d, want valid=1 idx=3",
               bus.grant_valid, bus.grant_idx);
    end
    tick();
  endtask

  task automatic test_lock_release();
    restart();
    drive(7'b0100000, 1'b0, 1'b1);  // lock on 5, ptr stays 0
    tick();
    drive(7'b0100010, 1'b0, 1'b0);
    n_cmp++;
    if (bus.grant_valid !== 1'b1 || bus.grant_idx !== IW'(5)) begin
      n_bad++;
      $display("FAIL lock_beats_ptr: got valid=%0b idx=%0d, want valid=1 idx=5",
               bus.grant_valid, bus.grant_idx);
    end
    // Re-lock 5 so the release below happens from a live lock.
    drive(7'b0100010, 1'b0, 1'b1);
    tick();
    drive(7'b0000010, 1'b0, 1'b0);
    n_cmp++;
    if (bus.grant_valid !== 1'b1 || bus.grant_idx !== IW'(1)) begin
      n_bad++;
      $display("FAIL lock_release_same_cycle: got valid=%0b idx=%0d, want valid=1 idx=1",
               bus.grant_valid, bus.grant_idx);
    end
    tick();
    drive(7'b0100010, 1'b0, 1'b0);
    n_cmp++;
    if (bus.grant_valid !== 1'b1 || bus.grant_idx !== IW'(1)) begin
      n_bad++;
      $display("FAIL lock_cleared: got valid=%0b idx=%0d, want valid=1 idx=1",
               bus.grant_valid, bus.grant_idx);
    end
    tick();
  endtask

  task automatic test_reset_mid_lock();
    restart();
    for (int i = 0; i < 3; i++) begin
      drive(7'h7F, 1'b1, 1'b0);
      tick();
    end
    drive(7'h7F, 1'b1, 1'b1);  // lock 3, ptr -> 4
    tick();
    reset = 1'b1;
    model_reset();
    drive(7'b0001100, 1'b1, 1'b1);
    n_cmp++;
    if (bus.grant_valid !== 1'b1 || bus.grant_idx !== IW'(2)) begin
      n_bad++;
      $display("FAIL reset_mid_lock: got valid=%0b idx=%0d, want valid=1 idx=2",
               bus.grant_valid, bus.grant_idx);
    end
    tick();
    reset = 1'b0;
    drive(7'h7F, 1'b0, 1'b0);
    n_cmp++;
    if (bus.grant_valid !== 1'b1 || bus.grant_idx !== IW'(0)) begin
      n_bad++;
      $display("FAIL reset_mid_lock_after: got valid=%0b idx=%0d, want valid=1 idx=0",
               bus.grant_valid, bus.grant_idx);
    end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] req;
    logic [N-1:0] oh;
    logic [N-1:0] oh_want;
    logic         upd;
    logic         lk;
    int           bad_here;
    restart();
    for (int i = 0; i < 600; i++) begin
      req = N'($urandom);
      if ($urandom_range(0, 3) == 0) req = req & N'($urandom);
      if ($urandom_range(0, 7) == 0) req = '0;
      upd = ($urandom_range(0, 3) != 0);
      lk  = ($urandom_range(0, 4) == 0);
      drive(req, upd, lk);
      // Downstream index-to-one-hot select, LSB0.
      oh      = bus.grant_valid ? (N'(1) << bus.grant_idx) : '0;
      oh_want = (exp_v != 0) ? (N'(1) << exp_i) : '0;
      bad_here = 0;
      if (bus.grant_valid !== 1'(exp_v) || bus.grant_idx !== IW'(exp_i)) bad_here = 1;
      if (oh !== oh_want || (bus.grant_valid === 1'b1 && (oh & req) == '0)) bad_here = 1;
      n_cmp++;
      if (bad_here != 0) begin
        n_bad++;
        $display("FAIL random[%0d] req=%b: got valid=%0b idx=%0d oh=%b, want valid=%0d idx=%0d oh=%b",
                 i, req, bus.grant_valid, bus.grant_idx, oh, exp_v, exp_i, oh_want);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.request    = '0;
    bus.update_lru = 1'b0;
    bus.grant_lock = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_rotation();
    test_wrap();
    test_idle();
    test_lock();
    test_lock_release();
    test_reset_mid_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
